// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } piso_state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Frame bit counter: loads WIDTH, decrements on enable, flags the last remaining bit.
module piso_bit_counter #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic last_bit
);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;

    // Next count: load has priority; decrement saturates at zero.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = CW'(WIDTH);
        end else if (dec && (count_r != {CW{1'b0}})) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register with registered last-bit flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= {CW{1'b0}};
            last_bit <= 1'b0;
        end else begin
            count_r  <= count_next_s;
            last_bit <= (count_next_s == CW'(1));
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// PISO serializer with selectable bit order; optional even-parity trailer bit
// is compiled in when PISO_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             direction,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    piso_state_t      state_r, state_next_s;
    logic [WIDTH-1:0] shreg_r, shreg_next_s;
    logic             dir_r, dir_next_s;
    logic             cnt_load_s, cnt_dec_s, last_bit_s;
    logic             serial_next_s;
`ifdef PISO_PARITY_EN
    logic             parity_r, parity_next_s;
`endif

    piso_bit_counter #(.WIDTH(WIDTH)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .last_bit (last_bit_s)
    );

    // Next-state, datapath updates, and next serial bit.
    always_comb begin
        state_next_s  = state_r;
        shreg_next_s  = shreg_r;
        dir_next_s    = dir_r;
        cnt_load_s    = 1'b0;
        cnt_dec_s     = 1'b0;
        serial_next_s = 1'b0;
`ifdef PISO_PARITY_EN
        parity_next_s = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (load_valid && load_ready) begin
                    shreg_next_s = load_data;
                    dir_next_s   = direction;
                    cnt_load_s   = 1'b1;
                    state_next_s = SHIFT;
`ifdef PISO_PARITY_EN
                    parity_next_s = even_parity(load_data);
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    cnt_dec_s = 1'b1;
                    if (dir_r == DIR_MSB_FIRST) begin
                        shreg_next_s = {shreg_r[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_next_s = {1'b0, shreg_r[WIDTH-1:1]};
                    end
                    if (last_bit_s) begin
`ifdef PISO_PARITY_EN
                        state_next_s = PARITY;
`else
                        state_next_s = DONE;
`endif
                    end else begin
                        state_next_s = SHIFT;
                    end
                end else begin
                    state_next_s = SHIFT;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (shift_en) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = PARITY;
                end
            end
`endif
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        // Outputs are registered, so the bit presented next cycle comes from next-state values.
        case (state_next_s)
            SHIFT: begin
                if (dir_next_s == DIR_MSB_FIRST) begin
                    serial_next_s = shreg_next_s[WIDTH-1];
                end else begin
                    serial_next_s = shreg_next_s[0];
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                serial_next_s = parity_next_s;
            end
`endif
            default: begin
                serial_next_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            shreg_r      <= {WIDTH{1'b0}};
            dir_r        <= DIR_LSB_FIRST;
            load_ready   <= 1'b1;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            shreg_r      <= shreg_next_s;
            dir_r        <= dir_next_s;
            load_ready   <= (state_next_s == IDLE);
            serial_out   <= serial_next_s;
            serial_valid <= (state_next_s == SHIFT) || (state_next_s == PARITY);
            busy         <= (state_next_s != IDLE);
            done         <= (state_next_s == DONE);
        end
    end

`ifdef PISO_PARITY_EN
    // Parity bit captured with the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_next_s;
        end
    end
`endif

endmodule
